// File: rtl/dist_fifo_if.sv
// Handshake bundle between producers, the FIFO controller and the consumer.
// slave  : controller view (accepts s_* words, presents m_* head)
// master : environment view (drives s_* words, consumes m_* head)
interface dist_fifo_if #(
  parameter int DATA_BITWIDTH = 8
);
  logic                     s_valid;
  logic                     s_ready;
  logic [DATA_BITWIDTH-1:0] s_data;
  logic                     m_valid;
  logic                     m_ready;
  logic [DATA_BITWIDTH-1:0] m_data;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

// File: rtl/dist_fifo_ctrl.sv
// FIFO controller for a dual-port distributed RAM with asynchronous reads.
// Owns the RAM write port and the second (read) port, prefetching the head
// word from dpo into a registered output stage. Total capacity is DEPTH+1.
// Optional feature macro: DIST_FIFO_FLUSH_EN adds a synchronous flush input.
module dist_fifo_ctrl #(
  parameter int DATA_BITWIDTH = 8,
  parameter int ADDR_BITWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  dist_fifo_if.slave               bus,
  output logic                     ram_we,
  output logic [ADDR_BITWIDTH-1:0] ram_a,
  output logic [DATA_BITWIDTH-1:0] ram_di,
  output logic [ADDR_BITWIDTH-1:0] ram_dpra,
  input  logic [DATA_BITWIDTH-1:0] ram_dpo,
`ifdef DIST_FIFO_FLUSH_EN
  input  logic                     flush,
`endif
  output logic [ADDR_BITWIDTH:0]   count
);

  // Extra MSB on the pointers distinguishes full from empty.
  logic [ADDR_BITWIDTH:0]   wr_ptr, rd_ptr, wr_ptr_next;
  logic                     ram_empty, ram_full;
  logic                     push, pop, load, flush_i;
  logic                     m_valid_q;
  logic [DATA_BITWIDTH-1:0] m_data_q;

`ifdef DIST_FIFO_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign ram_empty = (wr_ptr == rd_ptr);
  assign ram_full  = (wr_ptr[ADDR_BITWIDTH-1:0] == rd_ptr[ADDR_BITWIDTH-1:0]) &&
                     (wr_ptr[ADDR_BITWIDTH] != rd_ptr[ADDR_BITWIDTH]);

  // s_ready depends on pointers only, so no combinational path from m_ready.
  assign bus.s_ready = ~ram_full;
  assign push        = bus.s_valid & ~ram_full & ~rst;
  assign pop         = m_valid_q & bus.m_ready;
  // Refill the output register whenever it is empty or being drained.
  assign load        = ~ram_empty & (~m_valid_q | bus.m_ready);

  assign wr_ptr_next = wr_ptr + {{ADDR_BITWIDTH{1'b0}}, push};

  assign ram_we   = push;
  assign ram_a    = wr_ptr[ADDR_BITWIDTH-1:0];
  assign ram_di   = bus.s_data;
  assign ram_dpra = rd_ptr[ADDR_BITWIDTH-1:0];

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;

  // Occupancy: RAM entries (modular pointer difference) plus output register.
  assign count = (wr_ptr - rd_ptr) + {{ADDR_BITWIDTH{1'b0}}, m_valid_q};

  // Pointer and output-register update; flush drops everything incl. a same-cycle push.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      if (flush_i) begin
        rd_ptr    <= wr_ptr_next;
        m_valid_q <= 1'b0;
      end else if (load) begin
        m_data_q  <= ram_dpo;
        m_valid_q <= 1'b1;
        rd_ptr    <= rd_ptr + 1'b1;
      end else if (pop) begin
        m_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dist_fifo_ctrl.sv
// Self-checking bench for dist_fifo_ctrl (DEPTH=4): queue-level reference
// model compared every cycle, directed scenarios with literal expectations,
// then a randomized phase. Exercises flush when DIST_FIFO_FLUSH_EN is defined.
module tb_dist_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fl  = 1'b0;
  logic          ram_we;
  logic [AW-1:0] ram_a, ram_dpra;
  logic [DW-1:0] ram_di, ram_dpo;
  logic [AW:0]   count;
  logic [DW-1:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;

  dist_fifo_if #(.DATA_BITWIDTH(DW)) bus ();

  dist_fifo_ctrl #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di),
    .ram_dpra(ram_dpra), .ram_dpo(ram_dpo),
`ifdef DIST_FIFO_FLUSH_EN
    .flush(fl),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  // Distributed RAM: synchronous write, asynchronous read.
  always @(posedge clk) if (ram_we) mem[ram_a] <= ram_di;
  assign ram_dpo = mem[ram_dpra];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (queue of words) ----------------
  logic [DW-1:0] mq[$];
  bit            mv;
  logic [DW-1:0] md;
  int            wc, rc;
  bit            men = 0;
  bit            pu, ld, po;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete(); mv = 0; md = '0; wc = 0; rc = 0; men = 1;
    end else if (men) begin
      pu = bus.s_valid && (mq.size() < DEPTH);
      po = mv && bus.m_ready;
      ld = (mq.size() > 0) && (!mv || bus.m_ready);
      if (pu) wc++;
      if (fl) begin
        mq.delete(); mv = 0; rc = wc;
      end else begin
        if (ld) begin md = mq.pop_front(); mv = 1; rc++; end
        else if (po) mv = 0;
        if (pu) mq.push_back(bus.s_data);
      end
    end
  end

  // Every-cycle comparison, after inputs for the cycle have settled.
  always @(negedge clk) begin
    #3;
    if (men) begin
      chk("s_ready", bus.s_ready, mq.size() < DEPTH);
      chk("ram_we",  ram_we, !rst && bus.s_valid && (mq.size() < DEPTH));
      chk("count",   count, mq.size() + mv);
      chk("m_valid", bus.m_valid, mv);
      chk("ram_dpra", ram_dpra, rc % DEPTH);
      if (mv) chk("m_data", bus.m_data, md);
      if (ram_we) begin
        chk("ram_a",  ram_a, wc % DEPTH);
        chk("ram_di", ram_di, bus.s_data);
      end
    end
  end

  // Words actually handed downstream.
  logic [DW-1:0] rx[$];
  always @(posedge clk) if (!rst && bus.m_valid && bus.m_ready) rx.push_back(bus.m_data);

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    bus.s_valid = 0; bus.m_ready = 0; fl = 0; rst = 0;
  endtask

  task automatic do_reset();
    tick(); idle(); rst = 1;
    tick(); rst = 0;
  endtask

  initial begin
    bus.s_valid = 0; bus.s_data = '0; bus.m_ready = 0;
    repeat (2) tick();
    rst = 0;
    tick();
    // reset state
    chk("rst_count", count, 0);
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_ram_we", ram_we, 0);

    // 1: single word latency
    bus.s_valid = 1; bus.s_data = 8'h11;
    #1;
    chk("t1_ram_we", ram_we, 1);
    chk("t1_ram_a", ram_a, 0);
    tick(); bus.s_valid = 0;
    chk("t1_mv_early", bus.m_valid, 0);
    tick();
    chk("t1_m_valid", bus.m_valid, 1);
    chk("t1_m_data", bus.m_data, 8'h11);
    chk("t1_count", count, 1);

    // 2: fill to DEPTH+1
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      bus.s_valid = 1; bus.s_data = DW'(i);
      if (i == 6) chk("t2_full_s_ready", bus.s_ready, 0);
      tick();
    end
    bus.s_valid = 0;
    chk("t2_count", count, 5);
    chk("t2_s_ready", bus.s_ready, 0);
    chk("t2_m_data", bus.m_data, 8'h01);
    bus.m_ready = 1;
    tick(); bus.m_ready = 0;
    chk("t2_m_data2", bus.m_data, 8'h02);
    chk("t2_s_ready2", bus.s_ready, 1);

    // 3: streaming 20 words
    do_reset();
    rx.delete();
    begin
      int idx, cyc;
      idx = 0; cyc = 0;
      while (idx < 20 && cyc < 100) begin
        bus.s_valid = 1; bus.s_data = DW'(idx); bus.m_ready = 1;
        if (bus.s_ready) idx++;
        cyc++;
        tick();
      end
      bus.s_valid = 0;
      chk("t3_in_cycles", cyc, 20);
      cyc = 0;
      while (rx.size() < 20 && cyc < 20) begin tick(); cyc++; end
      chk("t3_rx_size", rx.size(), 20);
      for (int i = 0; i < 20 && i < rx.size(); i++) chk("t3_order", rx[i], i);
      bus.m_ready = 0;
    end

    // 4: hold stability
    do_reset();
    bus.s_valid = 1; bus.s_data = 8'hA0; tick();
    bus.s_data = 8'hA1; tick();
    bus.s_valid = 0; tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold", bus.m_data, 8'hA0);
      chk("t4_hold_v", bus.m_valid, 1);
      tick();
    end
    bus.m_ready = 1; tick(); bus.m_ready = 0;
    chk("t4_next", bus.m_data, 8'hA1);

    // 5: reset mid-transfer
    do_reset();
    for (int i = 0; i < 3; i++) begin bus.s_valid = 1; bus.s_data = 8'hC0 + DW'(i); tick(); end
    bus.s_valid = 0; rst = 1; tick(); rst = 0;
    chk("t5_m_valid", bus.m_valid, 0);
    chk("t5_count", count, 0);
    chk("t5_s_ready", bus.s_ready, 1);
    bus.s_valid = 1; bus.s_data = 8'hAA; tick(); bus.s_valid = 0; tick();
    chk("t5_first", bus.m_data, 8'hAA);
    chk("t5_first_v", bus.m_valid, 1);

`ifdef DIST_FIFO_FLUSH_EN
    // 6: flush with simultaneous push
    do_reset();
    for (int i = 0; i < 3; i++) begin bus.s_valid = 1; bus.s_data = 8'hB1 + DW'(i); tick(); end
    bus.s_data = 8'hEE; fl = 1; tick(); fl = 0; bus.s_valid = 0;
    chk("t6_count", count, 0);
    chk("t6_m_valid", bus.m_valid, 0);
    bus.s_valid = 1; bus.s_data = 8'h5A; tick(); bus.s_valid = 0; tick();
    chk("t6_first", bus.m_data, 8'h5A);
`endif

    // random phase, model-checked every cycle
    do_reset();
    for (int i = 0; i < 800; i++) begin
      bus.s_valid = ($urandom_range(3) != 0);
      bus.s_data  = DW'($urandom);
      bus.m_ready = ($urandom_range(2) != 0);
      rst = ($urandom_range(79) == 0);
`ifdef DIST_FIFO_FLUSH_EN
      fl = ($urandom_range(39) == 0);
`endif
      tick();
    end
    idle();
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dist_fifo_ctrl.md
# dist_fifo_ctrl

Synchronous FIFO controller that owns the write port and the second read port of a dual-port distributed RAM with asynchronous reads. Upstream producers push words in with a valid/ready handshake. The controller writes them into the RAM, prefetches the head word from the RAM's dpo output into an output register, and presents it downstream with a valid/ready handshake. It is the buffering stage between the feature/weight producers and the compute array.

## Interface
Parameters:
- DATA_BITWIDTH, 8, word width; must match the attached RAM.
- ADDR_BITWIDTH, 8, RAM address width; RAM depth is DEPTH = 2^ADDR_BITWIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  controller can accept a word.
- s_data  in  DATA_BITWIDTH  upstream word.
- m_valid  out  1  m_data holds the FIFO head.
- m_ready  in  1  downstream accepts the head.
- m_data  out  DATA_BITWIDTH  head word (registered).
- ram_we  out  1  RAM write enable.
- ram_a  out  ADDR_BITWIDTH  RAM write address (write pointer).
- ram_di  out  DATA_BITWIDTH  RAM write data.
- ram_dpra  out  ADDR_BITWIDTH  RAM read address (read pointer).
- ram_dpo  in  DATA_BITWIDTH  RAM asynchronous read data at ram_dpra.
- count  out  ADDR_BITWIDTH+1  total occupancy: RAM entries plus the output register.
- flush  in  1  present only with DIST_FIFO_FLUSH_EN.

## Operation
- Pointers: wr_ptr and rd_ptr are ADDR_BITWIDTH+1 bits. The low ADDR_BITWIDTH bits drive ram_a and ram_dpra.
  - ram_empty = (wr_ptr == rd_ptr).
  - ram_full = (low bits equal) and (MSBs differ).
- Push: push = s_valid & s_ready.
  - s_ready = ~ram_full. It is combinational from the pointers only and has no path from m_ready.
  - ram_we = push; ram_di = s_data.
  - On push, wr_ptr increments, wrapping modulo 2^(ADDR_BITWIDTH+1).
- Pop: pop = m_valid & m_ready.
- Load: load = ~ram_empty & (~m_valid | m_ready).
  - On load, m_data <= ram_dpo, m_valid <= 1, and rd_ptr increments.
  - If pop occurs without load, m_valid <= 0.
- No bypass path: a word pushed into an empty FIFO always passes through the RAM.
- Simultaneous push and pop:
  - Both proceed in the same cycle.
  - Simultaneous push and load are legal even when the RAM holds one entry, because the read and write addresses differ or the write lands after the read.
- Full condition: maximum occupancy is DEPTH+1 (DEPTH words in the RAM plus 1 in the output register).
  - With ram_full, s_ready is 0 regardless of m_ready.
  - s_ready rises in the cycle after a load frees a RAM entry.
- count = (wr_ptr - rd_ptr) + m_valid, computed modulo 2^(ADDR_BITWIDTH+1) for the subtraction. count is combinational from registers.
- Ordering is strict FIFO; no word is dropped or duplicated.

## Timing
- Reset values: wr_ptr=0, rd_ptr=0, m_valid=0, m_data=0, count=0, s_ready=1, ram_we=0 (ram_we=0 while s_valid=0).
- During reset, push is suppressed: ram_we=0 when rst=1. Reset mid-transfer discards all contents, and the RAM contents are left stale.
- First-word latency: word accepted at edge E is written at edge E, loaded at edge E+1, and m_valid=1 from E+1 onward. That is 2 cycles from s_valid to m_valid.
- Sustained throughput: 1 word/cycle in and out when s_valid=1 and m_ready=1.
- m_data and m_valid are stable while m_valid=1 and m_ready=0.

## Configuration
- DIST_FIFO_FLUSH_EN defined:
  - Adds the flush input.
  - flush=1 at an edge sets rd_ptr <= wr_ptr_next and m_valid <= 0. Any push in the same cycle is still written and then discarded, so count=0 after that edge.
  - flush has lower priority than rst.
- DIST_FIFO_FLUSH_EN not defined: no flush port; contents are cleared only by rst.

## Test plan
Bench uses ADDR_BITWIDTH=2, so DEPTH=4.
1. Reset, then push 0x11 with m_ready=0 → ram_we=1, ram_a=0 at the push edge; m_valid=1 and m_data=0x11 one cycle later; count=1.
2. Push 0x01..0x06 with m_ready=0 → 5 pushes accepted, s_ready=0 after the 5th, count=5, m_data=0x01. Then pulse m_ready for 1 cycle → m_data=0x02 and s_ready=1 on the next cycle.
3. Streaming with s_valid=m_ready=1 for 20 words → 1 word/cycle, output order 0..19, and ram_a/ram_dpra wrap 3→0 with no loss.
4. Hold m_ready=0 with m_valid=1 for 5 cycles → m_data is unchanged; then m_ready=1 → next word is presented.
5. Assert rst after 3 pushes → m_valid=0, count=0, s_ready=1 on the next cycle; a subsequent push of 0xAA emerges as the first word.
6. With DIST_FIFO_FLUSH_EN, fill 3 words and assert flush together with a push → count=0 and m_valid=0 after the edge; the next push of 0x5A emerges first.
